// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-path types and constants
// Contents:
//   fetch_entry_t : one buffered fetch slot {pc, instr}
//   FQ_DEPTH      : default fetch queue depth
//   FQ_WIDTH      : width of pc and instr
package mips_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int FQ_WIDTH = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - fetch-side and decode-side handshakes of the fetch queue
// Signals:
//   in_valid/in_ready/in_pc/in_instr     : fetch stage -> queue
//   out_valid/out_ready/out_pc/out_instr : queue -> fetch/decode register
// Modports:
//   master : the pipeline around the queue (fetch drives in_*, decode drives out_ready)
//   slave  : the queue itself
interface inst_fetch_queue_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_instr;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - DEPTH-entry circular instruction fetch queue
// Ports:
//   clk   : pipeline clock, all state changes on the rising edge
//   reset : synchronous active-high, empties the queue
//   flush : synchronous clear from the hazard unit, empties the queue
//   bus   : slave side of the fetch/decode handshakes
//   count : current occupancy
// Downstream the fetch/decode register uses en = out_ready and
// clr = flush || (!out_valid && out_ready) to insert a bubble on an empty pop.
module inst_fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    inst_fetch_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
    localparam logic [PW-1:0] ONE_PTR    = PW'(1);

    fetch_entry_t mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;

    // Both handshakes depend only on registered count, so a full queue
    // refuses a push even when decode pops in the same cycle.
    assign bus.in_ready  = (count != FULL_COUNT);
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Head is read straight from storage; when empty it shows a stale entry.
    assign bus.out_pc    = mem[rd_ptr].pc;
    assign bus.out_instr = mem[rd_ptr].instr;

    // Entry contents are never cleared; a push dropped by reset/flush is
    // harmless because wr_ptr does not advance over it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            unique case ({push, pop})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
        end
    end

endmodule
